// File: rtl/memory_arbiter_pkg.sv
// Shared types for the memory arbiter: RAM handshake states, word type and
// arbiter FSM states.
package memory_arbiter_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/memory_arbiter.sv
// Memory arbiter: multiplexes instruction-fetch and data requests onto a
// single-ported RAM. Data wins by default; a streak counter forces an
// instruction grant after DSTREAK_MAX back-to-back data grants, and a
// timeout counter aborts a grant the RAM never answers.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned DSTREAK_MAX = 4,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      err
);

    arb_state_t r_state;
    logic [3:0] r_streak;
    logic [7:0] r_tcount;

    arb_state_t w_next;
    logic       w_dreq;
    logic       w_ack;
    logic       w_timeout;

    assign w_dreq = dREN | dWEN;
    assign iload  = ramload;
    assign dload  = ramload;

    // Timeout fires on the grant cycle that would bring the count to TIMEOUT_CYC.
    assign w_timeout = (({1'b0, r_tcount} + 9'd1) == 9'(TIMEOUT_CYC));

    // Next-state, RAM strobes and handshake outputs; strobes depend only on
    // the registered state so no IDLE request reaches the RAM combinationally.
    always_comb begin
        w_next   = r_state;
        w_ack    = 1'b0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        err      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_dreq && !(iREN && (r_streak == 4'(DSTREAK_MAX))))
                    w_next = DGRANT;
                else if (iREN)
                    w_next = IGRANT;
            end
            DGRANT: begin
                if (!w_dreq) begin
                    w_next = IDLE;
                end else begin
                    ramWEN   = dWEN;
                    ramREN   = dREN & ~dWEN;
                    ramaddr  = daddr;
                    ramstore = dstore;
                    if (ramstate == ACCESS) begin
                        dwait  = 1'b0;
                        w_ack  = 1'b1;
                        w_next = IDLE;
                    end else if (ramstate == ERROR || w_timeout) begin
                        dwait  = 1'b0;
                        err    = 1'b1;
                        w_next = IDLE;
                    end
                end
            end
            IGRANT: begin
                if (!iREN) begin
                    w_next = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (ramstate == ACCESS) begin
                        iwait  = 1'b0;
                        w_ack  = 1'b1;
                        w_next = IDLE;
                    end else if (ramstate == ERROR || w_timeout) begin
                        iwait  = 1'b0;
                        err    = 1'b1;
                        w_next = IDLE;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // State register plus inline streak and timeout counters.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state  <= IDLE;
            r_streak <= '0;
            r_tcount <= '0;
        end else begin
            r_state <= w_next;

            if (r_state != IDLE && w_next != IDLE)
                r_tcount <= r_tcount + 8'd1;
            else
                r_tcount <= '0;

            if (r_state == DGRANT && w_ack && iREN) begin
                if (r_streak != 4'(DSTREAK_MAX))
                    r_streak <= r_streak + 4'd1;
            end else if (r_state == IGRANT && w_ack) begin
                r_streak <= '0;
            end else if (r_state == IDLE && !iREN) begin
                r_streak <= '0;
            end
        end
    end

    // Requesters must hold their address stable while a grant stays open.
    a_daddr_stable: assert property (@(posedge CLK) disable iff (!nRST)
        (r_state == DGRANT && w_next == DGRANT) |=> $stable(daddr));
    a_iaddr_stable: assert property (@(posedge CLK) disable iff (!nRST)
        (r_state == IGRANT && w_next == IGRANT) |=> $stable(iaddr));

endmodule
